// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial subtractor, D = A - B - b_in, LSB first, one bit per clock.
// Ports:
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   start               : operation request, sampled only while idle
//   A, B, b_in          : minuend, subtrahend, borrow-in (captured on accepted start)
//   D, b_out, zero, ovf : difference, final borrow, D==0 flag, signed overflow
//   busy, done          : operation in progress, one-cycle result-valid pulse
module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             b_in,
    output logic [WIDTH-1:0] D,
    output logic             b_out,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor cell shared by every bit position
    logic             bit_a, bit_b, diff_bit, borrow_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        bit_a      = sa_q[0];
        bit_b      = sb_q[0];
        diff_bit   = bit_a ^ bit_b ^ br_q;
        borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        res_nxt    = {diff_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = b_in;
                    amsb_d  = A[WIDTH-1];
                    bmsb_d  = B[WIDTH-1];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d = res_nxt;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = borrow_nxt;
                cnt_d = cnt_q + CW'(1);
                // Results are committed on the edge that processes the MSB,
                // so they are valid in the same cycle as done.
                if (cnt_q == LAST_BIT) begin
                    dout_d  = res_nxt;
                    bout_d  = borrow_nxt;
                    zero_d  = (res_nxt == '0);
                    ovf_d   = (amsb_q ^ bmsb_q) & (diff_bit ^ amsb_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign D     = dout_q;
    assign b_out = bout_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: directed self-checking bench for serial_sub4 (WIDTH=4).
module tb_serial_sub4;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       b_in;
    logic [3:0] D;
    logic       b_out;
    logic       zero;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_bad;

    serial_sub4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .b_in    (b_in),
        .D       (D),
        .b_out   (b_out),
        .zero    (zero),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; checks busy/done timing and the committed results.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bi, input logic [3:0] ed, input logic eb,
                          input logic ez, input logic eo);
        @(negedge clk);
        A = a; B = b; b_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_D"}, 32'(D), 32'(ed));
        chk({tag, "_bout"}, 32'(b_out), 32'(eb));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_D_hold"}, 32'(D), 32'(ed));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; b_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_bout", 32'(b_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;

        run_op("7m3",  4'd7, 4'd3,  1'b0, 4'd4,  1'b0, 1'b0, 1'b0);
        run_op("3m7",  4'd3, 4'd7,  1'b0, 4'd12, 1'b1, 1'b0, 1'b0);
        run_op("0m0b", 4'd0, 4'd0,  1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        run_op("5m5",  4'd5, 4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0);
        run_op("8m1",  4'd8, 4'd1,  1'b0, 4'd7,  1'b0, 1'b0, 1'b1);
        run_op("7m15", 4'd7, 4'd15, 1'b0, 4'd8,  1'b1, 1'b0, 1'b1);

        // Idle hold: results stay put while start is low
        repeat (3) @(negedge clk);
        chk("idle_D", 32'(D), 32'd8);
        chk("idle_ovf", 32'(ovf), 32'd1);

        // Start ignored while busy, operand changes after capture ignored
        @(negedge clk);
        A = 4'd9; B = 4'd2; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'd3; B = 4'd12;
        @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1; b_in = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 4'd15; B = 4'd0;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_D", 32'(D), 32'd7);
        chk("ign_bout", 32'(b_out), 32'd0);
        chk("ign_ovf", 32'(ovf), 32'd1);
        @(negedge clk);
        chk("ign_done_pulse", 32'(done), 32'd0);
        repeat (6) @(negedge clk);
        chk("ign_no_requeue", 32'(busy), 32'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        A = 4'd6; B = 4'd1; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_D", 32'(D), 32'd0);
        chk("mrst_zero", 32'(zero), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mrst_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst_after_done", 32'(done), 32'd0);
        chk("mrst_after_D", 32'(D), 32'd0);

        run_op("6m1", 4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_sub4.md
Name: serial_sub4

Overview:
- Bit-serial subtractor: computes D = A - B - b_in, one bit per clock, LSB first, using a single registered borrow.
- Companion to the combinational 4-bit ripple adder in the ALU. It gives the ALU a subtraction path that trades latency for one full-subtractor cell.
- Uses a start/busy/done handshake so the ALU control unit can sequence it.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; captured on the accepted start
B  input  WIDTH  subtrahend; captured on the accepted start
b_in  input  1  borrow-in; captured on the accepted start
D  output  WIDTH  difference A - B - b_in (mod 2^WIDTH)
b_out  output  1  final borrow: 1 when A < B + b_in (unsigned)
zero  output  1  D == 0
ovf  output  1  signed overflow of the two's-complement subtraction
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when results become valid

Behaviour:
- Reset (reset_n low, asynchronous): state goes to IDLE. D, b_out, ovf, busy and done are all 0; zero is 1. Internal shift registers, counter and borrow flop are cleared.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Capture A into shreg_a, B into shreg_b, b_in into the borrow flop.
  - Clear the bit counter; go to SHIFT; busy=1 from the next cycle.
- IDLE, start=0: hold; D, b_out, zero and ovf keep their last values.
- SHIFT, each cycle, with a=shreg_a[0], b=shreg_b[0], br=borrow flop:
  - Difference bit d = a ^ b ^ br.
  - Next borrow = (~a & b) | (~(a ^ b) & br).
  - d shifts into the result register from the MSB side; shreg_a and shreg_b shift right.
  - Counter increments. After WIDTH SHIFT cycles (counter reaches WIDTH-1 and that bit is processed), go to DONE.
- DONE, one cycle only:
  - D is loaded from the result register; b_out is the final borrow.
  - zero = (D == 0).
  - ovf = (A_msb != B_msb) & (D_msb != A_msb), using the captured operand MSBs.
  - done=1, busy=0. Next state is IDLE.
- Latency: start sampled at edge 0, so busy is high for cycles 1..WIDTH. done is high for exactly one cycle; D, b_out, zero and ovf become valid in the same cycle as done.
- Outputs D, b_out, zero and ovf change only on entry to DONE or on reset. They are stable between operations.
- start is ignored in SHIFT and DONE; there is no queuing. Changes on A, B or b_in after capture have no effect.
- Back-to-back operation: start held high continuously is accepted in IDLE only. Throughput is therefore one operation per WIDTH+2 cycles.
- Reset asserted mid-operation: abort immediately, return all outputs to reset values, and do not pulse done.
- Wrap-around: D is the result modulo 2^WIDTH; the borrow beyond the MSB appears only on b_out.

Test Plan:
- A=7, B=3, b_in=0, start for 1 cycle -> after 5 cycles done=1 for one cycle; D=4, b_out=0, zero=0, ovf=0; busy high exactly 4 cycles.
- A=3, B=7, b_in=0 -> D=12, b_out=1, zero=0, ovf=0.
- A=0, B=0, b_in=1 -> D=15, b_out=1, zero=0. Then A=5, B=5, b_in=0 -> D=0, b_out=0, zero=1.
- A=8 (-8), B=1, b_in=0 -> D=7, ovf=1, b_out=0. Then A=7, B=15 (-1) -> D=8, ovf=1, b_out=1.
- Start A=9, B=2; pulse start with A=1, B=1 during busy, and change A/B inputs mid-op -> second start ignored; D=7 when done.
- Start A=6, B=1; drop reset_n low at cycle 2 -> D=0, zero=1, busy=0 immediately; no done pulse. After release, A=6, B=1 completes with D=5.
